// File: rtl/mem_arb_pkg.sv
// Shared types and line-geometry constants for the memory arbiter.
package mem_arb_pkg;

   // Default line geometry: 128-bit lines, 16 bytes, 4 offset bits.
   localparam int unsigned LINE_BYTES       = 16;
   localparam int unsigned LINE_OFFSET_BITS = $clog2(LINE_BYTES);

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Requester identity.
   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_t;

   // Byte-offset bits within a line of the given bit width.
   function automatic int unsigned line_offset_bits(input int unsigned line_width);
      return $clog2(line_width / 8);
   endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner select between I-cache and D-cache requests.
// ROUND_ROBIN_EN: conflicts go to the port not granted last; otherwise the
// D-cache always wins a conflict.
module arb_picker
   import mem_arb_pkg::*;
(
   input  logic    ic_req,
   input  logic    dc_req,
`ifdef ROUND_ROBIN_EN
   input  req_id_t last_grant,
`endif
   output logic    grant_valid_c,
   output req_id_t grant_id_c
);

   // Pick a winner whenever at least one port is requesting.
   always_comb begin
      grant_valid_c = ic_req | dc_req;
      grant_id_c    = REQ_DC;
      if (ic_req && dc_req) begin
`ifdef ROUND_ROBIN_EN
         grant_id_c = (last_grant == REQ_DC) ? REQ_IC : REQ_DC;
`else
         grant_id_c = REQ_DC;
`endif
      end else if (ic_req) begin
         grant_id_c = REQ_IC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Line-level arbiter sharing one data memory between I-cache refill and
// D-cache refill/writeback. One memory pulse per grant, one ready pulse back.
// Build option: ROUND_ROBIN_EN selects round-robin conflict resolution;
// without it the D-cache has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 8 * LINE_BYTES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ic_req,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   output logic [LINE_WIDTH-1:0] ic_rdata,
   output logic                  ic_ready,
   input  logic                  dc_req,
   input  logic                  dc_we,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic [LINE_WIDTH-1:0] dc_wdata,
   output logic [LINE_WIDTH-1:0] dc_rdata,
   output logic                  dc_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int unsigned OFF_BITS = (LINE_WIDTH == 8 * LINE_BYTES) ?
                                      LINE_OFFSET_BITS : line_offset_bits(LINE_WIDTH);

   state_t  state;
   req_id_t owner;
   logic    grant_valid_c;
   req_id_t grant_id_c;
   logic [ADDR_WIDTH-1:0] ic_line_c;
   logic [ADDR_WIDTH-1:0] dc_line_c;

   // Line-aligned request addresses; byte offset bits forced to zero.
   assign ic_line_c = {ic_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
   assign dc_line_c = {dc_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

`ifdef ROUND_ROBIN_EN
   req_id_t last_grant;

   arb_picker u_picker (
      .ic_req        (ic_req),
      .dc_req        (dc_req),
      .last_grant    (last_grant),
      .grant_valid_c (grant_valid_c),
      .grant_id_c    (grant_id_c)
   );
`else
   arb_picker u_picker (
      .ic_req        (ic_req),
      .dc_req        (dc_req),
      .grant_valid_c (grant_valid_c),
      .grant_id_c    (grant_id_c)
   );
`endif

   // Transaction FSM: grant, single-cycle issue, wait for memory, ready pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= REQ_DC;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ic_ready  <= 1'b0;
         dc_ready  <= 1'b0;
         ic_rdata  <= '0;
         dc_rdata  <= '0;
`ifdef ROUND_ROBIN_EN
         last_grant <= REQ_DC;
`endif
      end else begin
         mem_req  <= 1'b0;
         ic_ready <= 1'b0;
         dc_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_valid_c) begin
                  owner   <= grant_id_c;
                  mem_req <= 1'b1;
`ifdef ROUND_ROBIN_EN
                  last_grant <= grant_id_c;
`endif
                  if (grant_id_c == REQ_DC) begin
                     mem_we    <= dc_we;
                     mem_addr  <= dc_line_c;
                     mem_wdata <= dc_wdata;
                  end else begin
                     // I-cache is read-only.
                     mem_we    <= 1'b0;
                     mem_addr  <= ic_line_c;
                     mem_wdata <= '0;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  if (owner == REQ_DC) begin
                     dc_rdata <= mem_rdata;
                     dc_ready <= 1'b1;
                  end else begin
                     ic_rdata <= mem_rdata;
                     ic_ready <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model with a bench-side memory.
module tb_mem_arbiter;

`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         ic_req;
   logic [31:0]  ic_addr;
   logic [127:0] ic_rdata;
   logic         ic_ready;
   logic         dc_req;
   logic         dc_we;
   logic [31:0]  dc_addr;
   logic [127:0] dc_wdata;
   logic [127:0] dc_rdata;
   logic         dc_ready;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_rdata  (ic_rdata),
      .ic_ready  (ic_ready),
      .dc_req    (dc_req),
      .dc_we     (dc_we),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_rdata  (dc_rdata),
      .dc_ready  (dc_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bench memory: 256 lines indexed by address bits [11:4]; responds
   // mem_lat cycles after a sampled request (random 1..3 in random mode).
   logic [127:0] mem_arr [256];
   int           mem_lat   = 1;
   bit           rand_mode = 1'b0;
   bit           mb_pend   = 1'b0;
   int           mb_resp_at;
   logic [7:0]   mb_idx;

   always @(negedge clk) begin
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (mb_pend && cyc == mb_resp_at) begin
         mem_ready = 1'b1;
         mem_rdata = mem_arr[mb_idx];
         mb_pend   = 1'b0;
      end
      if (mem_req === 1'b1) begin
         mb_idx = mem_addr[11:4];
         if (mem_we) mem_arr[mb_idx] = mem_wdata;
         mb_pend    = 1'b1;
         mb_resp_at = cyc + (rand_mode ? int'($urandom_range(1, 3)) : mem_lat);
      end
   end

   // Transaction-level model: one line transaction at a time; a grant shows
   // as a memory pulse the next cycle, completion follows the cycle after
   // the memory answers, and the port is free again one cycle later.
   bit           chk_en = 1'b0;
   bit           m_busy, m_issued, m_free, m_last_dc, m_own_dc;
   logic [7:0]   m_idx;
   logic         e_mem_req, e_mem_we, e_ic_ready, e_dc_ready;
   logic [31:0]  e_mem_addr;
   logic [127:0] e_mem_wdata, e_ic_rdata, e_dc_rdata;
   bit           e_wd_valid;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_issued = 1'b0; m_free = 1'b0; m_last_dc = 1'b1;
         e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0;
         e_ic_ready = 1'b0; e_dc_ready = 1'b0; e_ic_rdata = '0; e_dc_rdata = '0;
         e_wd_valid = 1'b1;
         chk_en = 1'b1;
      end else begin
         e_mem_req = 1'b0; e_ic_ready = 1'b0; e_dc_ready = 1'b0;
         if (m_free) begin
            m_busy = 1'b0;
            m_free = 1'b0;
         end else if (!m_busy) begin
            if (ic_req || dc_req) begin
               if (ic_req && dc_req) m_own_dc = RR ? !m_last_dc : 1'b1;
               else                  m_own_dc = dc_req;
               m_last_dc  = m_own_dc;
               m_busy     = 1'b1;
               m_issued   = 1'b0;
               e_mem_req  = 1'b1;
               e_mem_addr = (m_own_dc ? dc_addr : ic_addr) & 32'hFFFF_FFF0;
               e_mem_we   = m_own_dc ? dc_we : 1'b0;
               e_wd_valid = m_own_dc;
               if (m_own_dc) e_mem_wdata = dc_wdata;
               m_idx = e_mem_addr[11:4];
            end
         end else if (!m_issued) begin
            m_issued = 1'b1;
         end else if (mem_ready) begin
            if (m_own_dc) begin e_dc_ready = 1'b1; e_dc_rdata = mem_arr[m_idx]; end
            else          begin e_ic_ready = 1'b1; e_ic_rdata = mem_arr[m_idx]; end
            m_free = 1'b1;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_mem_req",  mem_req,  e_mem_req);
         check("cyc_mem_we",   mem_we,   e_mem_we);
         check("cyc_mem_addr", mem_addr, e_mem_addr);
         if (e_wd_valid) check("cyc_mem_wdata", mem_wdata, e_mem_wdata);
         check("cyc_ic_ready", ic_ready, e_ic_ready);
         check("cyc_dc_ready", dc_ready, e_dc_ready);
         check("cyc_ic_rdata", ic_rdata, e_ic_rdata);
         check("cyc_dc_rdata", dc_rdata, e_dc_rdata);
      end
   end

   // Raise one request, hold it until the ready pulse, drop it; report
   // latency, memory pulse count, issued addr/we and foreign ready pulses.
   task automatic run_txn(input bit is_dc, input bit we, input logic [31:0] a,
                          input logic [127:0] wd, output int lat, output int np,
                          output logic [31:0] sa, output bit sw, output int oth);
      @(negedge clk);
      if (is_dc) begin dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wdata = wd; end
      else       begin ic_req = 1'b1; ic_addr = a; end
      lat = 0; np = 0; sa = '0; sw = 1'b0; oth = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (mem_req) begin np++; sa = mem_addr; sw = mem_we; end
         if (is_dc ? ic_ready : dc_ready) oth++;
         if (is_dc ? dc_ready : ic_ready) begin lat = k; break; end
      end
      if (is_dc) dc_req = 1'b0; else ic_req = 1'b0;
      check("txn_completed", lat != 0, 1'b1);
   endtask

   localparam logic [127:0] L0 = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
   localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   initial begin
      int lat, np, oth, cnt, nic, ndc, n, drop_at;
      logic [31:0] sa;
      bit sw;
      int order [8];

      rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
      dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem_arr[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_arr[0] = L0;
      repeat (2) @(negedge clk);
      check("rst_mem_req",  mem_req,  1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_ic_ready", ic_ready, 1'b0);
      check("rst_dc_rdata", dc_rdata, 128'h0);
      rst = 1'b0;

      // I-cache read of a preloaded line.
      run_txn(1'b0, 1'b0, 32'h0001_0000, '0, lat, np, sa, sw, oth);
      check("t1_latency", lat, 3);
      check("t1_mem_pulses", np, 1);
      check("t1_mem_we", sw, 1'b0);
      check("t1_mem_addr", sa, 32'h0001_0000);
      check("t1_ic_rdata", ic_rdata, L0);
      check("t1_dc_quiet", oth, 0);

      // D-cache writeback to an unaligned address, then read back.
      run_txn(1'b1, 1'b1, 32'h0001_0013, W1, lat, np, sa, sw, oth);
      check("t2_mem_addr", sa, 32'h0001_0010);
      check("t2_mem_we", sw, 1'b1);
      check("t2_latency", lat, 3);
      run_txn(1'b1, 1'b0, 32'h0001_0010, '0, lat, np, sa, sw, oth);
      check("t2_readback", dc_rdata, W1);

      // Slow memory: answer five cycles later than nominal.
      mem_lat = 6;
      run_txn(1'b0, 1'b0, 32'h0001_0020, '0, lat, np, sa, sw, oth);
      check("t4_latency", lat, 8);
      check("t4_mem_pulses", np, 1);
      mem_lat = 1;

      // Reset while waiting on memory; the late answer must be ignored.
      @(negedge clk);
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0001_0030; mem_lat = 6;
      repeat (3) @(negedge clk);
      rst = 1'b1; dc_req = 1'b0;
      @(negedge clk);
      check("t5_mem_req", mem_req, 1'b0);
      check("t5_mem_addr", mem_addr, 32'h0);
      check("t5_dc_rdata", dc_rdata, 128'h0);
      check("t5_ic_rdata", ic_rdata, 128'h0);
      rst = 1'b0;
      mem_lat = 1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ic_ready || dc_ready) cnt++;
      end
      check("t5_no_late_ready", cnt, 0);
      run_txn(1'b0, 1'b0, 32'h0001_0040, '0, lat, np, sa, sw, oth);
      check("t5_fresh_latency", lat, 3);
      check("t5_fresh_rdata", ic_rdata, mem_arr[4]);

      // Request held one cycle past ready: exactly one extra transaction.
      @(negedge clk);
      ic_req = 1'b1; ic_addr = 32'h0001_0050;
      np = 0; cnt = 0; drop_at = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_req) np++;
         if (ic_ready) begin
            cnt++;
            if (drop_at < 0) drop_at = k + 2;
         end
         if (k == drop_at) ic_req = 1'b0;
      end
      ic_req = 1'b0;
      check("t6_mem_pulses", np, 2);
      check("t6_ready_pulses", cnt, 2);

      // Simultaneous continuous requests, four transactions each.
      @(negedge clk);
      ic_req = 1'b1; ic_addr = 32'h0001_0060;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0001_0070;
      nic = 0; ndc = 0; n = 0;
      for (int i = 0; i < 8; i++) order[i] = -1;
      for (int k = 0; k < 200 && (nic < 4 || ndc < 4); k++) begin
         @(negedge clk);
         if (ic_ready && n < 8) begin order[n] = 0; n++; nic++; if (nic == 4) ic_req = 1'b0; end
         if (dc_ready && n < 8) begin order[n] = 1; n++; ndc++; if (ndc == 4) dc_req = 1'b0; end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      check("t3_count", n, 8);
      check("t3_first_dc", order[0], 1);
`ifdef ROUND_ROBIN_EN
      for (int i = 1; i < 8; i++) check("t3_alternate", order[i] != order[i-1], 1'b1);
`else
      for (int i = 0; i < 8; i++) check("t3_fixed_order", order[i], (i < 4) ? 1 : 0);
`endif

      // Random traffic with random memory latency.
      rand_mode = 1'b1;
      nic = 0; ndc = 0;
      for (int k = 0; k < 900; k++) begin
         @(negedge clk);
         if (ic_req) begin
            if (ic_ready) begin ic_req = 1'b0; nic++; end
         end else if (k < 800 && $urandom_range(0, 2) == 0) begin
            ic_req = 1'b1; ic_addr = $urandom & 32'h0001_0FFF;
         end
         if (dc_req) begin
            if (dc_ready) begin dc_req = 1'b0; ndc++; end
         end else if (k < 800 && $urandom_range(0, 2) == 0) begin
            dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1));
            dc_addr = $urandom & 32'h0001_0FFF;
            dc_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check("t7_drained", {ic_req, dc_req}, 2'b00);
      check("t7_ic_served", nic > 10, 1'b1);
      check("t7_dc_served", ndc > 10, 1'b1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
